// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target that decodes START/STOP, matches a 7-bit address, accepts a
//   register pointer followed by write data into a small register file, and
//   returns read data from the same file. SCL is never stretched.
//
// Ports
//   clk_i      system clock (>= 16x SCL)
//   rst_i      synchronous active-high reset
//   scl_i      resolved bus SCL level
//   sda_i      resolved bus SDA level
//   sda_o      open-drain SDA drive (0 pulls low, 1 releases)
//   busy_o     high from a matched address until STOP
//   start_o    one-cycle pulse on START / repeated START
//   stop_o     one-cycle pulse on STOP
//   wr_stb_o   one-cycle pulse when a data byte is committed
//   wr_addr_o  register index of the committed byte
//   wr_data_o  committed byte
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         DEPTH      = 16,
  localparam int        PW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          busy_o,
  output logic          start_o,
  output logic          stop_o,
  output logic          wr_stb_o,
  output logic [PW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] WR       = 4'd4;
  localparam logic [3:0] WR_ACK   = 4'd5;
  localparam logic [3:0] RD       = 4'd6;
  localparam logic [3:0] RD_ACK   = 4'd7;
  localparam logic [3:0] IGNORE   = 4'd8;

  // ---------------------------------------------------------------------
  // Pin conditioning: lane 0 = SCL, lane 1 = SDA. Two synchronizer flops
  // followed by a history flop for edge detection. Reset to the idle-high
  // bus level so no spurious edge appears when reset releases.
  // ---------------------------------------------------------------------
  logic [1:0] pin;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] hist_reg;

  assign pin = {sda_i, scl_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
          hist_reg[gi]  <= 1'b1;
        end else begin
          sync1_reg[gi] <= pin[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          hist_reg[gi]  <= sync2_reg[gi];
        end
      end
    end
  endgenerate

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_s    = sync2_reg[0];
  assign sda_s    = sync2_reg[1];
  assign scl_rise =  scl_s & ~hist_reg[0];
  assign scl_fall = ~scl_s &  hist_reg[0];
  // SCL must be high in both the current and previous sample: an SDA edge
  // coinciding with an SCL edge is a data event, not a bus condition.
  assign start_det = ~sda_s &  hist_reg[1] & scl_s & hist_reg[0];
  assign stop_det  =  sda_s & ~hist_reg[1] & scl_s & hist_reg[0];

  // ---------------------------------------------------------------------
  // Protocol FSM and register file
  // ---------------------------------------------------------------------
  logic [3:0]    state_reg;
  logic [3:0]    cnt_reg;      // SCL rises seen in the current byte
  logic [7:0]    shift_reg;
  logic [PW-1:0] ptr_reg;
  logic          rw_reg;
  logic          ack_reg;      // master's ACK/NACK after a read byte
  logic          drive_reg;    // SDA level decided by the FSM
  logic          busy_reg;
  logic          start_reg;
  logic          stop_reg;
  logic          wr_pend_reg;
  logic [PW-1:0] wr_addr_pend_reg;
  logic [7:0]    wr_data_pend_reg;
  logic [7:0]    mem_reg [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      shift_reg        <= '0;
      ptr_reg          <= '0;
      rw_reg           <= 1'b0;
      ack_reg          <= 1'b1;
      drive_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      start_reg        <= 1'b0;
      stop_reg         <= 1'b0;
      wr_pend_reg      <= 1'b0;
      wr_addr_pend_reg <= '0;
      wr_data_pend_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      start_reg   <= start_det;
      stop_reg    <= stop_det;
      wr_pend_reg <= 1'b0;

      if (stop_det) begin
        state_reg <= IDLE;
        drive_reg <= 1'b1;
        busy_reg  <= 1'b0;
        cnt_reg   <= '0;
      end else if (start_det) begin
        // Release SDA even if an illegal START arrives while we pull low;
        // the pointer survives a repeated START.
        state_reg <= ADDR;
        drive_reg <= 1'b1;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ADDR, PTR, WR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              cnt_reg   <= cnt_reg + 4'd1;
            end else if (scl_fall && cnt_reg == 4'd8) begin
              cnt_reg <= '0;
              if (state_reg == ADDR) begin
                if (shift_reg[7:1] == SLAVE_ADDR) begin
                  state_reg <= ADDR_ACK;
                  drive_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  rw_reg    <= shift_reg[0];
                end else begin
                  state_reg <= IGNORE;
                  drive_reg <= 1'b1;
                end
              end else if (state_reg == PTR) begin
                ptr_reg   <= shift_reg[PW-1:0];
                state_reg <= WR_ACK;
                drive_reg <= 1'b0;
              end else begin
                mem_reg[ptr_reg] <= shift_reg;
                wr_pend_reg      <= 1'b1;
                wr_addr_pend_reg <= ptr_reg;
                wr_data_pend_reg <= shift_reg;
                ptr_reg          <= ptr_reg + 1'b1;
                state_reg        <= WR_ACK;
                drive_reg        <= 1'b0;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              cnt_reg <= '0;
              if (rw_reg) begin
                shift_reg <= mem_reg[ptr_reg];
                drive_reg <= mem_reg[ptr_reg][7];
                ptr_reg   <= ptr_reg + 1'b1;
                state_reg <= RD;
              end else begin
                // The byte right after the address is always the first
                // write byte since START, so it selects the pointer.
                drive_reg <= 1'b1;
                state_reg <= PTR;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              drive_reg <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= WR;
            end
          end

          RD: begin
            if (scl_rise) begin
              cnt_reg <= cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (cnt_reg == 4'd8) begin
                drive_reg <= 1'b1;
                cnt_reg   <= '0;
                state_reg <= RD_ACK;
              end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                drive_reg <= shift_reg[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              ack_reg <= sda_s;
            end else if (scl_fall) begin
              cnt_reg <= '0;
              if (!ack_reg) begin
                shift_reg <= mem_reg[ptr_reg];
                drive_reg <= mem_reg[ptr_reg][7];
                ptr_reg   <= ptr_reg + 1'b1;
                state_reg <= RD;
              end else begin
                drive_reg <= 1'b1;
                state_reg <= IGNORE;
              end
            end
          end

          default: begin
            // IDLE and IGNORE wait for START or STOP only.
            drive_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: one extra register on SDA and the write strobe so both
  // land 4 clocks after the SCL fall, well inside the SCL-low window.
  // ---------------------------------------------------------------------
  logic          sda_out_reg;
  logic          wr_stb_reg;
  logic [PW-1:0] wr_addr_reg;
  logic [7:0]    wr_data_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_out_reg <= 1'b1;
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      sda_out_reg <= drive_reg;
      wr_stb_reg  <= wr_pend_reg;
      if (wr_pend_reg) begin
        wr_addr_reg <= wr_addr_pend_reg;
        wr_data_reg <= wr_data_pend_reg;
      end
    end
  end

  assign sda_o     = sda_out_reg;
  assign busy_o    = busy_reg;
  assign start_o   = start_reg;
  assign stop_o    = stop_reg;
  assign wr_stb_o  = wr_stb_reg;
  assign wr_addr_o = wr_addr_reg;
  assign wr_data_o = wr_data_reg;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder
//   Directed bench: a behavioural I2C master drives scl/sda (wired-AND with
//   the target's sda_o), and a negedge monitor counts target pulses.
module tb_i2c_slave_responder;

  localparam int Q = 8;  // clk cycles per quarter SCL period (32x ratio)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       busy_o;
  logic       start_o;
  logic       stop_o;
  logic       wr_stb_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & sda_o;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .DEPTH(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_o    (sda_o),
    .busy_o   (busy_o),
    .start_o  (start_o),
    .stop_o   (stop_o),
    .wr_stb_o (wr_stb_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  int sda_low_cnt, busy_cnt, start_cnt, stop_cnt, wr_cnt;
  int wr_a_log [16];
  int wr_d_log [16];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_mon();
    sda_low_cnt = 0; busy_cnt = 0; start_cnt = 0; stop_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      wr_a_log[i] = -1;
      wr_d_log[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!sda_o)   sda_low_cnt++;
      if (busy_o)   busy_cnt++;
      if (start_o)  start_cnt++;
      if (stop_o)   stop_cnt++;
      if (wr_stb_o) begin
        if (wr_cnt < 16) begin
          wr_a_log[wr_cnt] = int'(wr_addr_o);
          wr_d_log[wr_cnt] = int'(wr_data_o);
        end
        wr_cnt++;
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL period: set SDA mid-low, sample mid-high.
  task automatic bit_cycle(input logic b, output logic s);
    wait_q(); sda_m = b;
    wait_q(); scl_m = 1'b1;
    wait_q(); s = sda_i;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    send_bits(d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      d = {d[6:0], s};
    end
    bit_cycle(ack_bit, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;

    clear_mon();
    repeat (5) @(negedge clk);
    check_value("rst_sda_o", 32'(sda_o), 32'd1);
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_wr_stb", 32'(wr_stb_o), 32'd0);
    check_value("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check_value("rst_wr_data", 32'(wr_data_o), 32'd0);
    rst = 1'b0;

    // Idle bus
    repeat (100) @(negedge clk);
    check_value("idle_sda_low", sda_low_cnt, 0);
    check_value("idle_busy", busy_cnt, 0);
    check_value("idle_start", start_cnt, 0);
    check_value("idle_stop", stop_cnt, 0);
    check_value("idle_wr", wr_cnt, 0);

    // Write: pointer 5, data 78, A5
    clear_mon();
    i2c_start();
    write_byte(8'h44, ack); check_value("wr_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check_value("wr_ack_ptr", 32'(ack), 32'd0);
    write_byte(8'h78, ack); check_value("wr_ack_d0", 32'(ack), 32'd0);
    write_byte(8'hA5, ack); check_value("wr_ack_d1", 32'(ack), 32'd0);
    i2c_stop();
    check_value("wr_count", wr_cnt, 2);
    check_value("wr0_addr", wr_a_log[0], 5);
    check_value("wr0_data", wr_d_log[0], 32'h78);
    check_value("wr1_addr", wr_a_log[1], 6);
    check_value("wr1_data", wr_d_log[1], 32'hA5);
    check_value("wr_start_cnt", start_cnt, 1);
    check_value("wr_stop_cnt", stop_cnt, 1);
    check_value("wr_busy_seen", 32'(busy_cnt != 0), 32'd1);
    check_value("wr_busy_after_stop", 32'(busy_o), 32'd0);

    // Read back via repeated START
    clear_mon();
    i2c_start();
    write_byte(8'h44, ack); check_value("rd_ack_waddr", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check_value("rd_ack_ptr", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check_value("rd_ack_raddr", 32'(ack), 32'd0);
    read_byte(1'b0, rd); check_value("rd_byte0", 32'(rd), 32'h78);
    read_byte(1'b1, rd); check_value("rd_byte1", 32'(rd), 32'hA5);
    repeat (Q) @(negedge clk);
    check_value("rd_sda_released", 32'(sda_o), 32'd1);
    i2c_stop();
    check_value("rd_start_cnt", start_cnt, 2);
    check_value("rd_busy_after_stop", 32'(busy_o), 32'd0);
    check_value("rd_wr_count", wr_cnt, 0);

    // Wrong address
    clear_mon();
    i2c_start();
    write_byte(8'h46, ack); check_value("na_ack_addr", 32'(ack), 32'd1);
    write_byte(8'h12, ack); check_value("na_ack_b0", 32'(ack), 32'd1);
    write_byte(8'h34, ack); check_value("na_ack_b1", 32'(ack), 32'd1);
    i2c_stop();
    check_value("na_sda_low", sda_low_cnt, 0);
    check_value("na_wr", wr_cnt, 0);
    check_value("na_busy", busy_cnt, 0);

    // Pointer wrap-around
    clear_mon();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h11, ack); check_value("wrap_ack_d0", 32'(ack), 32'd0);
    write_byte(8'h22, ack); check_value("wrap_ack_d1", 32'(ack), 32'd0);
    i2c_stop();
    check_value("wrap_wr_count", wr_cnt, 2);
    check_value("wrap_wr0_addr", wr_a_log[0], 15);
    check_value("wrap_wr0_data", wr_d_log[0], 32'h11);
    check_value("wrap_wr1_addr", wr_a_log[1], 0);
    check_value("wrap_wr1_data", wr_d_log[1], 32'h22);
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h0F, ack);
    i2c_start();
    write_byte(8'h45, ack); check_value("wrap_ack_raddr", 32'(ack), 32'd0);
    read_byte(1'b0, rd); check_value("wrap_rd0", 32'(rd), 32'h11);
    read_byte(1'b1, rd); check_value("wrap_rd1", 32'(rd), 32'h22);
    i2c_stop();

    // Reset during the ACK of a write data byte
    clear_mon();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h05, ack);
    send_bits(8'h33);
    sda_m = 1'b1;
    wait_q();
    check_value("mrst_ack_driven", 32'(sda_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("mrst_sda_released", 32'(sda_o), 32'd1);
    @(negedge clk); rst = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); wait_q(); scl_m = 1'b0;
    clear_mon();
    write_byte(8'h55, ack); check_value("mrst_ignored_ack", 32'(ack), 32'd1);
    check_value("mrst_ignored_wr", wr_cnt, 0);
    check_value("mrst_ignored_sda", sda_low_cnt, 0);
    i2c_start();
    write_byte(8'h44, ack); check_value("mrst_new_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'h45, ack);
    read_byte(1'b1, rd); check_value("mrst_mem_cleared", 32'(rd), 32'h00);
    i2c_stop();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
